// File: rtl/dm_responder_pkg.sv
// Shared definitions for the dm_responder data-memory responder.
// Holds the FSM encoding, parameter defaults, log-field widths and the error rule.
package dm_responder_pkg;

    localparam int unsigned DefaultDepthWords = 3072;
    localparam int unsigned DefaultLatency    = 2;
    localparam int unsigned CntWidth          = 4;

    localparam int unsigned LogPcWidth   = 32;
    localparam int unsigned LogAddrWidth = 32;
    localparam int unsigned LogDataWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Misaligned or beyond the last word of storage.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        logic [33:0] limit;
        limit = 34'(depth_words) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/dm_responder_ram.sv
// Word storage for dm_responder: synchronous write, combinational read,
// asynchronous clear of every word while reset is low.
module dm_responder_ram
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DefaultDepthWords
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [29:0] waddr,
    input  logic [31:0] wdata,
    input  logic [29:0] raddr,
    output logic [31:0] rdata
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    logic            w_in_range;
    logic            r_in_range;
    logic [IdxW-1:0] widx;
    logic [IdxW-1:0] ridx;

    assign w_in_range = ({2'b00, waddr} < 32'(DEPTH_WORDS));
    assign r_in_range = ({2'b00, raddr} < 32'(DEPTH_WORDS));
    assign widx       = IdxW'(waddr);
    assign ridx       = IdxW'(raddr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (we && w_in_range) begin
            mem[widx] <= wdata;
        end
    end

    // Out-of-range reads never reach the array.
    assign rdata = r_in_range ? mem[ridx] : '0;

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding load/store responder with fixed response latency and a
// store commit log. FSM, latency counter and handshakes live here.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
    parameter int unsigned LATENCY     = DefaultLatency
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [31:0]             req_pc,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    log_valid,
    output logic [LogPcWidth-1:0]   log_pc,
    output logic [LogAddrWidth-1:0] log_addr,
    output logic [LogDataWidth-1:0] log_data
);

    localparam logic [CntWidth-1:0] CntInit = CntWidth'(LATENCY - 1);

    state_e              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         pc_q;

    logic                access;
    logic                err;
    logic                ram_we;
    logic [31:0]         ram_rdata;

    assign req_ready = (state_q == StIdle);
    assign access    = (state_q == StWait) && (cnt_q == '0);
    assign err       = addr_err(addr_q, DEPTH_WORDS);
    assign ram_we    = access && we_q && !err;

    dm_responder_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (addr_q[31:2]),
        .wdata (wdata_q),
        .raddr (addr_q[31:2]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            log_valid <= 1'b0;
            log_pc    <= '0;
            log_addr  <= '0;
            log_data  <= '0;
        end else begin
            // log_valid is a single-cycle pulse following the commit edge.
            log_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        cnt_q   <= CntInit;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || we_q) ? '0 : ram_rdata;
                        if (ram_we) begin
                            log_valid <= 1'b1;
                            log_pc    <= pc_q;
                            log_addr  <= {addr_q[31:2], 2'b00};
                            log_data  <= wdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072, number of 32-bit words in storage (12 KiB).
REQ-002 Parameter LATENCY, default 2, clock edges from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_pc  input  32  PC of the issuing instruction; used for the write log only.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  32  load data: 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.
REQ-015 log_valid  output  1  one-cycle pulse when a store commits.
REQ-016 log_pc, log_addr, log_data  output  32 each  PC, word-aligned byte address and data of the committed store.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; exactly one request is outstanding at a time.
REQ-018 req_ready is 1 in IDLE only, and is a registered-state decode with no dependence on req_valid.
REQ-019 A request is accepted on an edge where req_valid and req_ready are both 1; at that edge the responder latches we/addr/wdata/pc, loads the counter with LATENCY-1 and enters WAIT.
REQ-020 In WAIT, at each edge: if counter is 0, the responder performs the access and enters RESP; otherwise it decrements the counter.
REQ-021 rsp_valid goes high exactly LATENCY edges after the acceptance edge.
REQ-022 Error: latched addr[1:0] != 0 or addr >= DEPTH_WORDS*4 → rsp_err=1, rsp_rdata=0, no storage write, no log pulse.
REQ-023 Word index = addr[31:2]; a legal load returns the stored word in rsp_rdata.
REQ-024 A legal store writes the word on the WAIT→RESP edge, pulses log_valid for exactly the following cycle with log_* equal to the latched pc/addr/wdata, and drives rsp_rdata=0.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready=1; on that edge the FSM returns to IDLE.
REQ-026 After a response is consumed, req_ready rises in the next cycle, so there is no same-edge response/accept overlap and the minimum request spacing is LATENCY+2 cycles.
REQ-027 req_* inputs are ignored outside IDLE; rsp_ready is ignored outside RESP.
REQ-028 Back-to-back store then load to the same address returns the new data.
REQ-029 rsp_valid=0 and log_valid=0 in IDLE and WAIT.

Reset
REQ-030 While reset=0: FSM=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, log_valid=0, log_*=0, all storage words=0.
REQ-031 req_ready=1 in the first cycle after reset deasserts.
REQ-032 Reset during WAIT discards the pending request; a store not yet committed leaves no trace in storage or the log.
REQ-033 Reset during RESP drops the response with no further rsp_valid.

Structure
REQ-034 A shared package holds the FSM state encodings, the DEPTH_WORDS and LATENCY defaults, and the log-field widths.
REQ-035 Storage is a sub-module dm_responder_ram (synchronous write, combinational read, asynchronous clear); the FSM, counter and handshake logic stay in dm_responder.

Verification
REQ-036 Reset then store addr=0x10, data=0xDEADBEEF, pc=0x3000 with LATENCY=2 → rsp_valid 2 edges after accept, rsp_err=0, log_valid pulse with 0x3000/0x10/0xDEADBEEF.
REQ-037 Load addr=0x10 after the above → rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 Store addr=0x13, then store addr=0x3000 (DEPTH 3072) → rsp_err=1 for both, no log pulse; a subsequent load of 0x10 still returns 0xDEADBEEF.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_rdata stable and req_ready=0 throughout; req_ready=1 in the cycle after the rsp_ready=1 edge.
REQ-040 Assert reset in WAIT of a store to 0x20 with data 0x1 → no log pulse, rsp_valid stays 0, and a load of 0x20 returns 0.
REQ-041 Run with LATENCY=1 and LATENCY=15 → rsp_valid exactly 1 and 15 edges after accept respectively.
